dsp48_mac_ctrl: RTL and testbench

DSP48_MAC_CTRL -- requirements
Module: dsp48_mac_ctrl

---
 rtl/dsp48_mac_ctrl_pkg.sv | 34 +++
 rtl/dsp48_mac_ctrl_tok_pipe.sv | 41 ++++
 rtl/dsp48_mac_ctrl.sv | 139 +++++++++++++
 tb/tb_dsp48_mac_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp48_mac_ctrl_pkg.sv
// Shared definitions for the DSP48 multiply-accumulate controller.
// Holds the controller FSM state type, the slice OPMODE values the
// controller issues, and the depth of the operand token pipe that
// mirrors the slice A1/B1 -> M -> P register chain.
package dsp48_mac_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // OPMODE with X=M, Z=0: P loads the first product of a job.
  localparam logic [7:0] OPM_MUL = 8'h01;
  // OPMODE with X=M, Z=P: P accumulates every later product.
  localparam logic [7:0] OPM_MAC = 8'h09;
  // OPMODE driven while no product reaches the P stage.
  localparam logic [7:0] OPM_OFF = 8'h00;

  // One stage per slice register: A1/B1, M, P.
  localparam int TOK_STAGES = 3;

  // OPMODE for the product currently sitting in the M register.
  function automatic logic [7:0] stage_opmode(input logic valid, input logic first);
    if (!valid) begin
      return OPM_OFF;
    end else if (first) begin
      return OPM_MUL;
    end else begin
      return OPM_MAC;
    end
  endfunction

endpackage

// File: rtl/dsp48_mac_ctrl_tok_pipe.sv
// Token shift register that tracks operand pairs through the slice
// register chain. Index 0 follows the A1/B1 registers, index 1 the M
// register and index 2 the P register. A new token enters every cycle;
// a cycle without an accepted pair shifts in an all-zero bubble.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   tok_valid     an operand pair was accepted this cycle
//   tok_first     that pair is the first of its job
//   tok_last      that pair is the last of its job
//   stage_valid   per-stage valid flags
//   stage_first   per-stage first flags
//   stage_last    per-stage last flags
module mac_tok_pipe
  import dsp48_mac_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tok_valid,
  input  logic                  tok_first,
  input  logic                  tok_last,
  output logic [TOK_STAGES-1:0] stage_valid,
  output logic [TOK_STAGES-1:0] stage_first,
  output logic [TOK_STAGES-1:0] stage_last
);

  // Advance unconditionally so the token timing matches the slice
  // registers, whose clock enables are derived from these flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= '0;
      stage_first <= '0;
      stage_last  <= '0;
    end else begin
      stage_valid <= {stage_valid[TOK_STAGES-2:0], tok_valid};
      stage_first <= {stage_first[TOK_STAGES-2:0], tok_first};
      stage_last  <= {stage_last[TOK_STAGES-2:0],  tok_last};
    end
  end

endmodule

// File: rtl/dsp48_mac_ctrl.sv
// Controller for a DSP48 slice running a dot product. It accepts
// len operand pairs, steers the slice clock enables and OPMODE so the
// first product loads P and the rest accumulate into it, and pulses
// res_valid/done when P holds the final sum.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   start, len   begin a job of len pairs (sampled only in IDLE)
//   in_valid     operand pair present on the slice A/B inputs
//   in_ready     controller takes a pair this cycle
//   ce_ab        slice A1/B1 clock enable
//   ce_m         slice M clock enable
//   ce_p         slice P clock enable
//   opmode       slice OPMODE (slice has OPMODEREG=0)
//   busy         job in progress
//   res_valid    slice P holds the final sum (single-cycle pulse)
//   done         job complete (single-cycle pulse, also for len=0)
module dsp48_mac_ctrl
  import dsp48_mac_ctrl_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ce_ab,
  output logic             ce_m,
  output logic             ce_p,
  output logic [7:0]       opmode,
  output logic             busy,
  output logic             res_valid,
  output logic             done
);

  state_t                state_q;
  state_t                state_d;
  logic [LEN_W-1:0]      remaining_q;
  logic                  first_pend_q;
  logic                  zero_done_q;
  logic                  accept;
  logic                  start_job;
  logic                  start_empty;
  logic                  last_pair;
  logic                  unused_tok;
  logic [TOK_STAGES-1:0] stage_valid;
  logic [TOK_STAGES-1:0] stage_first;
  logic [TOK_STAGES-1:0] stage_last;

  assign accept      = in_valid && in_ready;
  assign start_job   = (state_q == IDLE) && start && (len != '0);
  assign start_empty = (state_q == IDLE) && start && (len == '0);
  assign last_pair   = (remaining_q == LEN_W'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs. in_ready is gated with a nonzero
  // count so the counter can never be decremented through zero.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_job) begin
          state_d = RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = (remaining_q != '0);
        if (accept && last_pair) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (stage_valid[2] && stage_last[2]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pair counter and first-pair marker. An empty job leaves a one-cycle
  // marker so done pulses the cycle after start without touching the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_q  <= '0;
      first_pend_q <= 1'b0;
      zero_done_q  <= 1'b0;
    end else begin
      zero_done_q <= start_empty;
      if (start_job) begin
        remaining_q  <= len;
        first_pend_q <= 1'b1;
      end else if (accept) begin
        remaining_q  <= remaining_q - LEN_W'(1);
        first_pend_q <= 1'b0;
      end
    end
  end

  mac_tok_pipe u_tok_pipe (
    .clk         (clk),
    .rst         (rst),
    .tok_valid   (accept),
    .tok_first   (accept && first_pend_q),
    .tok_last    (accept && last_pair),
    .stage_valid (stage_valid),
    .stage_first (stage_first),
    .stage_last  (stage_last)
  );

  // Flags that ride along with a token but are not consumed at that stage.
  assign unused_tok = ^{stage_first[0], stage_first[2], stage_last[1:0]};

  // Each slice register is enabled only when a real token reaches it, so
  // bubbles leave M and P untouched.
  assign ce_ab     = accept;
  assign ce_m      = stage_valid[0];
  assign ce_p      = stage_valid[1];
  assign opmode    = stage_opmode(stage_valid[1], stage_first[1]);
  assign res_valid = stage_valid[2] && stage_last[2];
  assign done      = res_valid || zero_done_q;

endmodule

// File: tb/tb_dsp48_mac_ctrl.sv
// Self-checking bench for dsp48_mac_ctrl. A behavioural DSP48 slice
// (A1/B1 -> M -> P) is driven by the controller's enables and OPMODE.
// Expected sums and OPMODE sequences are queued as stimulus is generated
// and checked by a negedge monitor when the DUT produces them.
module tb_dsp48_mac_ctrl;

  localparam int LEN_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic             ce_ab;
  logic             ce_m;
  logic             ce_p;
  logic [7:0]       opmode;
  logic             busy;
  logic             res_valid;
  logic             done;

  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic [7:0]  a1;
  logic [7:0]  b1;
  logic [15:0] m_reg;
  logic [31:0] p_reg;

  logic [31:0] sum_q[$];
  logic [7:0]  opm_q[$];

  int checks;
  int errors;
  int cyc;
  int last_acc_cyc;
  int acc_count;
  logic zero_pending;
  logic acc_d1;
  logic acc_d2;

  dsp48_mac_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ce_ab     (ce_ab),
    .ce_m      (ce_m),
    .ce_p      (ce_p),
    .opmode    (opmode),
    .busy      (busy),
    .res_valid (res_valid),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Behavioural slice with OPMODEREG=0.
  always @(posedge clk) begin
    if (ce_ab) begin
      a1 <= a_in;
      b1 <= b_in;
    end
    if (ce_m) m_reg <= a1 * b1;
    if (ce_p) begin
      if (opmode == 8'h01) p_reg <= {16'h0, m_reg};
      else if (opmode == 8'h09) p_reg <= p_reg + {16'h0, m_reg};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Monitor: enable timing against observed accepts, OPMODE and result
  // against the scoreboard, and 3-cycle result latency.
  always @(negedge clk) begin
    logic acc;
    if (rst) begin
      acc_d1 = 1'b0;
      acc_d2 = 1'b0;
    end else begin
      acc = in_valid && in_ready;
      checkOutput("ce_ab", ce_ab, acc);
      checkOutput("ce_m", ce_m, acc_d1);
      checkOutput("ce_p", ce_p, acc_d2);
      if (ce_p) begin
        if (opm_q.size() == 0) checkOutput("opm_unexpected", 1, 0);
        else checkOutput("opmode", opmode, opm_q.pop_front());
      end else begin
        checkOutput("opmode_idle", opmode, 8'h00);
      end
      if (res_valid) begin
        if (sum_q.size() == 0) checkOutput("res_unexpected", 1, 0);
        else checkOutput("p_sum", p_reg, sum_q.pop_front());
        checkOutput("latency", cyc - last_acc_cyc, 3);
        checkOutput("done_with_res", done, 1);
      end else if (!zero_pending) begin
        checkOutput("done_alone", done, 0);
      end
      if (acc) begin
        last_acc_cyc = cyc;
        acc_count++;
      end
      acc_d2 = acc_d1;
      acc_d1 = acc;
    end
  end

  // Run one job: queue expectations, present pairs (optional gap after
  // pair gap_after, optional start pulse while pair inject_at waits),
  // then wait for the controller to go idle.
  task automatic applyStimulus(input int n, input int gap_after, input int gap_len,
                               input int inject_at);
    logic [7:0]  av[$];
    logic [7:0]  bv[$];
    logic [31:0] sum;
    int waitc;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      av.push_back(8'($urandom_range(0, 255)));
      bv.push_back(8'($urandom_range(0, 255)));
      sum = sum + 32'(av[i]) * 32'(bv[i]);
      opm_q.push_back((i == 0) ? 8'h01 : 8'h09);
    end
    sum_q.push_back(sum);
    acc_count = 0;
    start = 1'b1;
    len = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      a_in = av[i];
      b_in = bv[i];
      if (i == inject_at) begin
        start = 1'b1;
        len = LEN_W'(n + 3);
      end
      waitc = 0;
      @(negedge clk);
      while (!in_ready && waitc < 20) begin
        @(negedge clk);
        waitc++;
      end
      checkOutput("accept_wait", in_ready, 1);
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b0;
      if (waitc >= 20) break;
      if (i == gap_after) begin
        repeat (gap_len) @(posedge clk);
        #1;
      end
    end
    waitc = 0;
    @(negedge clk);
    while (busy && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    checkOutput("job_end", busy, 0);
    checkOutput("accept_count", acc_count, n);
    checkOutput("result_seen", sum_q.size(), 0);
    checkOutput("opm_drained", opm_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    last_acc_cyc = 0;
    acc_count = 0;
    zero_pending = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {in_ready, ce_ab, ce_m, ce_p, busy, res_valid, done, opmode}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] len=4 streaming");
    applyStimulus(4, -1, 0, -1);

    $display("[TB] len=3 with bubbles");
    applyStimulus(3, 0, 2, -1);

    $display("[TB] len=1");
    applyStimulus(1, -1, 0, -1);

    $display("[TB] len=0");
    zero_pending = 1'b1;
    start = 1'b1;
    len = '0;
    @(negedge clk);
    checkOutput("len0_busy_at_start", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("len0_done", done, 1);
    checkOutput("len0_res", res_valid, 0);
    checkOutput("len0_ready", in_ready, 0);
    checkOutput("len0_busy", busy, 0);
    @(negedge clk);
    checkOutput("len0_done_once", done, 0);
    checkOutput("len0_busy_after", busy, 0);
    zero_pending = 1'b0;
    @(posedge clk); #1;

    $display("[TB] reset mid-job");
    acc_count = 0;
    start = 1'b1;
    len = LEN_W'(5);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    a_in = 8'd17;
    b_in = 8'd23;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    checkOutput("midjob_accepts", acc_count, 2);
    checkOutput("midjob_rst_outputs", {in_ready, ce_ab, ce_m, ce_p, busy, res_valid, done, opmode}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("post_rst_idle", {in_ready, busy, res_valid, done}, 0);
    applyStimulus(2, -1, 0, -1);

    $display("[TB] start ignored while running");
    applyStimulus(4, -1, 0, 1);

    $display("[TB] full-range length");
    applyStimulus(255, -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
